dpram: RTL
==========

# dpram

Parametrised simple-dual-port synchronous RAM for the core's data and instruction memories. It has one write port with per-byte mask and one independent read port. Read latency is configurable, and the read-data path is registered with a valid strobe. Same-address read/write collisions are resolved by a selectable bypass policy. It generalises the single-port chip-select RAM wrapper so that fetch and load/store can access memory in the same cycle.

## Interface
- DP, 4096, depth in words.
- AW, 12, address width in words; DP ≤ 2^AW.
- DW, 32, data width in bits; multiple of 8.
- MW, DW/8, number of byte-mask bits.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- BYPASS, 1, collision policy: 1 = write-first (new data), 0 = read-first (old data).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request this cycle.
- wr_addr  in  AW  write word address.
- wr_data  in  DW  write data.
- wr_mask  in  MW  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request this cycle.
- rd_addr  in  AW  read word address.
- rd_data  out  DW  read data; valid when rd_valid=1, otherwise holds its last value.
- rd_valid  out  1  one-cycle strobe, RD_LAT cycles after the accepted rd_en.

## Operation
- Write: on a rising edge with wr_en=1 and wr_addr<DP, bytes with wr_mask[i]=1 are updated and the other bytes are retained.
- wr_en=1 with wr_mask=0 is a no-op.
- A write with wr_addr≥DP is silently dropped.
- Read: a rising edge with rd_en=1 samples rd_addr and captures the addressed word into stage 1.
  - RD_LAT=1: stage 1 drives rd_data/rd_valid directly.
  - RD_LAT=2: an extra register stage is inserted.
- Reads are fully pipelined. A new rd_en is accepted every cycle, with no back-pressure and no stall port.
- A read with rd_addr≥DP returns all zeros, and rd_valid still fires.
- Collision (rd_en & wr_en & rd_addr==wr_addr, both in range, same edge):
  - BYPASS=1: the returned word is the pre-write word with masked bytes replaced by wr_data, merged per byte.
  - BYPASS=0: the returned word is the pre-write word.
- Writes issued after the read's sampling edge are never visible in that read's result, including during RD_LAT=2 stage 2.
- The memory array is not reset. Its contents after power-up are undefined, and the bench must write before reading.
- Reset asserted mid-operation: in-flight reads are discarded, rd_valid=0 and rd_data=0 immediately (asynchronous). Any write on the edge coinciding with reset assertion is not guaranteed.

## Timing
- Reset values: rd_valid=0, rd_data=0, pipeline valid bits=0.
- Deassertion of rst_n is synchronous to the clk domain by the system. The first rd_en is accepted on the first edge with rst_n=1.
- Write latency: the new data is visible to a read sampled on the next edge (E+1).
- Under BYPASS=1, the write is also visible to a read sampled on the same edge E.
- Read latency: rd_en sampled on edge N produces rd_valid=1 and correct rd_data after edge N+RD_LAT, for exactly one cycle.
- rd_en on consecutive edges produces back-to-back rd_valid with no bubbles.
- rd_data changes only on edges where the final stage is loaded with a valid read.
- Single read port and single write port: no port-internal conflicts beyond collisions.
- Parameter checks: RD_LAT outside {1,2}, DW%8≠0 or DP>2^AW must trigger an elaboration-time error.

## Test plan
- Reset then idle:
  - Stimulus: hold rst_n=0 for 3 cycles, release, keep rd_en=0 for 5 cycles.
  - Required: rd_valid=0 and rd_data=0 throughout.
- Basic write/read, RD_LAT=1:
  - Stimulus: write 0xDEADBEEF to addr 5 with mask 4'hF, then rd_en at addr 5 on the next edge.
  - Required: rd_valid=1 one cycle later with rd_data=0xDEADBEEF.
  - Repeat with RD_LAT=2: the same data arrives two cycles after rd_en.
- Byte mask:
  - Stimulus: write 0x11223344 to addr 7, then 0xAABBCCDD with mask 4'b0101.
  - Required: a read of addr 7 returns 0x11BB33DD.
- Collision:
  - Stimulus: preload addr 3 = 0x00000000, then on the same edge write 0xFFFFFFFF mask 4'b0011 and read addr 3.
  - Required with BYPASS=1: 0x0000FFFF.
  - Required with BYPASS=0: 0x00000000.
  - Required for a follow-up read under either policy: 0x0000FFFF.
- Streaming and range:
  - Stimulus: with DP=1000, AW=10, write addr i = i*3 for i=0..9, then read addrs 0..9 back-to-back plus addr 1020.
  - Required: 11 contiguous rd_valid pulses returning 0,3,…,27, then 0 for addr 1020; the write to addr 1020 is dropped.
- Reset mid-read:
  - Stimulus: with RD_LAT=2, issue a read, then assert rst_n=0 one cycle later.
  - Required: rd_valid stays 0, and no stale data appears after reset release.

Source files
------------

// File: rtl/dpram.sv
// ============================================================================
// Module      : dpram
// Description : Simple-dual-port synchronous RAM. One write port with per-byte
//               mask, one independent fully pipelined read port with a
//               registered data path and valid strobe. Read latency is 1 or 2
//               cycles; same-address collisions are resolved write-first or
//               read-first depending on BYPASS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram #(
    parameter int DP     = 4096,   // depth in words
    parameter int AW     = 12,     // word address width
    parameter int DW     = 32,     // data width in bits
    parameter int MW     = DW / 8, // byte-mask width
    parameter int RD_LAT = 1,      // read latency, 1 or 2
    parameter int BYPASS = 1       // 1 = write-first, 0 = read-first
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
        $error("dpram: RD_LAT must be 1 or 2");
    end
    if ((DW % 8) != 0) begin : g_chk_dw
        $error("dpram: DW must be a multiple of 8");
    end
    if (MW != DW / 8) begin : g_chk_mw
        $error("dpram: MW must equal DW/8");
    end
    if (DP > (1 << AW)) begin : g_chk_dp
        $error("dpram: DP must not exceed 2**AW");
    end

    // Depth widened by one bit so the range compare works even when DP == 2**AW.
    localparam logic [AW:0] c_dp = (AW + 1)'(DP);

    // Storage is intentionally not reset; contents are undefined until written.
    logic [DW-1:0] r_mem [0:DP-1];

    logic          w_wr_in_range;
    logic          w_rd_in_range;
    logic          w_collide;
    logic [DW-1:0] w_rd_word;

    logic          r_s1_valid;
    logic [DW-1:0] r_s1_data;

    assign w_wr_in_range = ({1'b0, wr_addr} < c_dp);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_dp);
    // Only an accepted write can collide; a dropped out-of-range write cannot.
    assign w_collide     = wr_en && w_wr_in_range && (wr_addr == rd_addr);

    // Byte-masked write; out-of-range addresses are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_in_range) begin
            for (int i = 0; i < MW; i++) begin
                if (wr_mask[i]) begin
                    r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Word captured by a read: pre-write contents, optionally merged with the
    // bytes being written on the same edge (write-first), zero when out of range.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr];
            if (BYPASS == 1 && w_collide) begin
                for (int i = 0; i < MW; i++) begin
                    if (wr_mask[i]) begin
                        w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Stage 1: sample the read request; data only moves on a valid read so the
    // output holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= rd_en;
            if (rd_en) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stage selection
    // ------------------------------------------------------------------------
    if (RD_LAT == 2) begin : g_lat2
        logic          r_s2_valid;
        logic [DW-1:0] r_s2_data;

        // Stage 2: plain copy of stage 1, so later writes cannot leak in.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rd_valid = r_s2_valid;
        assign rd_data  = r_s2_data;
    end else begin : g_lat1
        assign rd_valid = r_s1_valid;
        assign rd_data  = r_s1_data;
    end

endmodule

`default_nettype wire
